// File: rtl/backward_sequencer.sv
// Backward-pass sequencer: walks the backward datapath through its stage codes,
// one pass per accepted start, with stall, abort and a saturating pass counter.
module backward_sequencer #(
   parameter int LEN_DADZ   = 5,
   parameter int LEN_DELTA3 = 4,
   parameter int LEN_DELTA2 = 5,
   parameter int LEN_DCDW   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        hold,
   input  logic        abort,
   input  logic [3:0]  st_in,
   input  logic [3:0]  st1_in,
   input  logic [1:0]  act_in,
   output logic [3:0]  step,
   output logic [3:0]  controller,
   output logic [3:0]  st,
   output logic [3:0]  st1,
   output logic [1:0]  act,
   output logic        busy,
   output logic        done,
   output logic [15:0] pass_cnt
);

   // State encodings double as the step codes, so step is the state register itself.
   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_LOAD   = 4'd1,
      S_DADZ   = 4'd6,
      S_DELTA3 = 4'd7,
      S_DELTA2 = 4'd8,
      S_DCDW   = 4'd9,
      S_UPDATE = 4'd10
   } state_t;

   localparam logic [3:0] L_DADZ_LAST   = 4'(LEN_DADZ - 1);
   localparam logic [3:0] L_DELTA3_LAST = 4'(LEN_DELTA3 - 1);
   localparam logic [3:0] L_DELTA2_LAST = 4'(LEN_DELTA2 - 1);
   localparam logic [3:0] L_DCDW_LAST   = 4'(LEN_DCDW - 1);

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_ctrl;
   logic [3:0]  w_ctrl_next;
   logic        w_accept;
   logic        w_done_next;
   logic        r_busy;
   logic        r_done;
   logic [15:0] r_pass_cnt;
   logic [3:0]  r_st;
   logic [3:0]  r_st1;
   logic [1:0]  r_act;

   always_comb begin
      w_next      = r_state;
      w_ctrl_next = r_ctrl;
      w_accept    = 1'b0;
      w_done_next = 1'b0;
      if (r_state == S_IDLE) begin
         w_ctrl_next = 4'd0;
         if (start && !abort) begin
            w_next   = S_LOAD;
            w_accept = 1'b1;
         end
      end else if (abort) begin
         w_next      = S_IDLE;
         w_ctrl_next = 4'd0;
      end else if (!hold) begin
         case (r_state)
            S_LOAD: begin
               w_next      = S_DADZ;
               w_ctrl_next = 4'd0;
            end
            S_DADZ:
               if (r_ctrl == L_DADZ_LAST) begin
                  w_next      = S_DELTA3;
                  w_ctrl_next = 4'd0;
               end else w_ctrl_next = r_ctrl + 4'd1;
            S_DELTA3:
               if (r_ctrl == L_DELTA3_LAST) begin
                  w_next      = S_DELTA2;
                  w_ctrl_next = 4'd0;
               end else w_ctrl_next = r_ctrl + 4'd1;
            S_DELTA2:
               if (r_ctrl == L_DELTA2_LAST) begin
                  w_next      = S_DCDW;
                  w_ctrl_next = 4'd0;
               end else w_ctrl_next = r_ctrl + 4'd1;
            S_DCDW:
               if (r_ctrl == L_DCDW_LAST) begin
                  w_next      = S_UPDATE;
                  w_ctrl_next = 4'd0;
               end else w_ctrl_next = r_ctrl + 4'd1;
            S_UPDATE: begin
               w_next      = S_IDLE;
               w_ctrl_next = 4'd0;
               w_done_next = 1'b1;
            end
            default: begin
               w_next      = S_IDLE;
               w_ctrl_next = 4'd0;
            end
         endcase
      end
   end

   // busy/done are registered from the next state so they line up with step.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_ctrl     <= 4'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_pass_cnt <= 16'd0;
         r_st       <= 4'd0;
         r_st1      <= 4'd0;
         r_act      <= 2'd0;
      end else begin
         r_state <= w_next;
         r_ctrl  <= w_ctrl_next;
         r_busy  <= (w_next != S_IDLE);
         r_done  <= w_done_next;
         if (w_done_next && (r_pass_cnt != 16'hFFFF))
            r_pass_cnt <= r_pass_cnt + 16'd1;
         if (w_accept) begin
            r_st  <= st_in;
            r_st1 <= st1_in;
            r_act <= act_in;
         end
      end
   end

   assign step       = r_state;
   assign controller = r_ctrl;
   assign busy       = r_busy;
   assign done       = r_done;
   assign pass_cnt   = r_pass_cnt;
   assign st         = r_st;
   assign st1        = r_st1;
   assign act        = r_act;

endmodule

// File: tb/tb_backward_sequencer.sv
// Scoreboard bench for backward_sequencer: the driver pushes the expected
// registered outputs for each edge; a monitor pops and compares after the edge.
module tb_backward_sequencer;

   logic        clk = 1'b0;
   logic        rst, start, hold, abort;
   logic [3:0]  st_in, st1_in;
   logic [1:0]  act_in;
   logic [3:0]  step, controller, st, st1;
   logic [1:0]  act;
   logic        busy, done;
   logic [15:0] pass_cnt;

   backward_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .hold(hold), .abort(abort),
      .st_in(st_in), .st1_in(st1_in), .act_in(act_in),
      .step(step), .controller(controller), .st(st), .st1(st1), .act(act),
      .busy(busy), .done(done), .pass_cnt(pass_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  step;
      logic [3:0]  ctrl;
      logic        busy;
      logic        done;
      logic [15:0] cnt;
      logic [3:0]  st;
      logic [3:0]  st1;
      logic [1:0]  act;
   } exp_t;

   exp_t  q_exp[$];
   string q_name[$];
   int    n_cmp  = 0;
   int    n_fail = 0;

   logic [15:0] exp_cnt = 16'd0;
   logic [3:0]  exp_st = 4'd0, exp_st1 = 4'd0;
   logic [1:0]  exp_act = 2'd0;
   logic [3:0]  g_st = 4'd0, g_st1 = 4'd0;
   logic [1:0]  g_act = 2'd0;
   logic        bg_start = 1'b0;
   string       tname = "reset";

   // Apply inputs for the coming edge and queue what the outputs must be after it.
   task automatic drive(input logic s, input logic h, input logic a, input logic r,
                        input logic [3:0] es, input logic [3:0] ec,
                        input logic eb, input logic ed);
      exp_t e;
      @(negedge clk);
      start = s; hold = h; abort = a; rst = r;
      st_in = g_st; st1_in = g_st1; act_in = g_act;
      e.step = es; e.ctrl = ec; e.busy = eb; e.done = ed;
      e.cnt = exp_cnt; e.st = exp_st; e.st1 = exp_st1; e.act = exp_act;
      q_exp.push_back(e);
      q_name.push_back(tname);
   endtask

   task automatic start_pass(input logic [3:0] s, input logic [3:0] s1,
                             input logic [1:0] a, input logic h);
      g_st = s; g_st1 = s1; g_act = a;
      exp_st = s; exp_st1 = s1; exp_act = a;
      drive(1'b1, h, 1'b0, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0);
      g_st = ~s; g_st1 = ~s1; g_act = ~a;
   endtask

   task automatic seg(input logic [3:0] code, input int len);
      for (int i = 0; i < len; i++)
         drive(bg_start, 1'b0, 1'b0, 1'b1, code, 4'(i), 1'b1, 1'b0);
   endtask

   task automatic finish_pass();
      drive(bg_start, 1'b0, 1'b0, 1'b1, 4'd10, 4'd0, 1'b1, 1'b0);
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      drive(bg_start, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1);
   endtask

   task automatic idle(input logic h, input int n);
      for (int i = 0; i < n; i++)
         drive(1'b0, h, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
   endtask

   initial begin : monitor
      exp_t  e;
      exp_t  got;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (q_exp.size() > 0) begin
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            got = '{step, controller, busy, done, pass_cnt, st, st1, act};
            n_cmp++;
            if (got !== e) begin
               n_fail++;
               $display("FAIL %s t=%0t got step=%0d ctrl=%0d busy=%b done=%b cnt=%h st=%h st1=%h act=%h want step=%0d ctrl=%0d busy=%b done=%b cnt=%h st=%h st1=%h act=%h",
                        nm, $time, got.step, got.ctrl, got.busy, got.done, got.cnt, got.st, got.st1, got.act,
                        e.step, e.ctrl, e.busy, e.done, e.cnt, e.st, e.st1, e.act);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin : stim
      rst = 1'b0; start = 1'b1; hold = 1'b1; abort = 1'b0;
      st_in = 4'd5; st1_in = 4'd6; act_in = 2'd1;
      tname = "reset";
      drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

      tname = "nominal";
      start_pass(4'd3, 4'd4, 2'd2, 1'b0);
      seg(4'd6, 5); seg(4'd7, 4); seg(4'd8, 5); seg(4'd9, 5);
      finish_pass();
      tname = "idle_hold";
      idle(1'b1, 2);

      tname = "stall";
      start_pass(4'd7, 4'd1, 2'd3, 1'b1);
      seg(4'd6, 5);
      seg(4'd7, 3);
      for (int i = 0; i < 3; i++)
         drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 4'd2, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 4'd3, 1'b1, 1'b0);
      seg(4'd8, 5); seg(4'd9, 5);
      finish_pass();
      idle(1'b0, 1);

      tname = "abort";
      start_pass(4'd9, 4'd2, 2'd1, 1'b0);
      seg(4'd6, 5); seg(4'd7, 4); seg(4'd8, 2);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
      idle(1'b0, 3);

      tname = "back2back";
      bg_start = 1'b1;
      for (int p = 0; p < 2; p++) begin
         start_pass(4'(p + 10), 4'(p + 12), 2'(p), 1'b0);
         seg(4'd6, 5); seg(4'd7, 4); seg(4'd8, 5); seg(4'd9, 5);
         finish_pass();
      end
      bg_start = 1'b0;
      idle(1'b0, 1);

      tname = "reset_mid";
      start_pass(4'd6, 4'd8, 2'd2, 1'b0);
      seg(4'd6, 5); seg(4'd7, 4); seg(4'd8, 5); seg(4'd9, 2);
      exp_cnt = 16'd0; exp_st = 4'd0; exp_st1 = 4'd0; exp_act = 2'd0;
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      tname = "start_abort_idle";
      drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
      idle(1'b0, 1);

      tname = "saturate";
      @(negedge clk);
      force dut.r_pass_cnt = 16'hFFFE;
      exp_cnt = 16'hFFFE;
      idle(1'b0, 1);
      release dut.r_pass_cnt;
      idle(1'b0, 1);
      for (int p = 0; p < 2; p++) begin
         start_pass(4'd1, 4'd2, 2'd3, 1'b0);
         seg(4'd6, 5); seg(4'd7, 4); seg(4'd8, 5); seg(4'd9, 5);
         finish_pass();
      end
      idle(1'b0, 2);

      repeat (3) @(negedge clk);
      if (q_exp.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain got %0d pending want 0", q_exp.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
